// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B    = 2'b00,
    SZ_H    = 2'b01,
    SZ_W    = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int WORD_BYTES = 4;

  // Store byte-enable for an access of size sz at byte offset lo.
  function automatic logic [WORD_BYTES-1:0] byte_mask(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_B:    byte_mask = 4'b0001 << lo;
      SZ_H:    byte_mask = 4'b0011 << {lo[1], 1'b0};
      SZ_W:    byte_mask = 4'b1111;
      default: byte_mask = '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store request and response channels between core and data memory.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  size_e             req_size;
  logic              req_unsigned;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/replication and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wrep_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  // Replicate store data across lanes; mask picks the lanes actually written.
  always_comb begin
    be_o = byte_mask(size_i, lo_i);
    case (size_i)
      SZ_B:    wrep_o = {4{wdata_i[7:0]}};
      SZ_H:    wrep_o = {2{wdata_i[15:0]}};
      default: wrep_o = wdata_i;
    endcase
  end

  // Pick the addressed lane from the word and extend it to 32 bits.
  always_comb begin
    ld_b = rword_i[{lo_i, 3'b000} +: 8];
    ld_h = lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_B:    rdata_o = uns_i ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      SZ_H:    rdata_o = uns_i ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      SZ_W:    rdata_o = rword_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: owns DM, services byte/half/word loads and stores
// with WAIT_CYCLES busy cycles between accept and response.
// Optional macro DMEM_MISALIGN_CHK_EN: misaligned accesses fault instead of
// being silently aligned down.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);

  logic [31:0] DM [DEPTH_WORDS];

  state_e            state_q;
  logic              req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;
  logic [CW-1:0]     cnt_q;
  logic              we_q, uns_q;
  logic [ADDR_W-1:0] addr_q;
  size_e             size_q;
  logic [31:0]       wdata_q;

  // With zero wait states the access happens on the accept edge, so the
  // operation fields come straight from the bus while idle.
  logic              in_idle, accept, enter_resp, wr_en, err;
  logic              op_we, op_uns;
  logic [ADDR_W-1:0] op_addr;
  size_e             op_size;
  logic [31:0]       op_wdata, rword, wrep, ld_data;
  logic [1:0]        lo;
  logic [3:0]        be;
  logic [ADDR_W-3:0] idx;
  logic              err_mis;

  assign in_idle    = (state_q == IDLE);
  assign accept     = in_idle && bus.req_valid && req_ready_q;
  assign enter_resp = (accept && NO_WAIT) || (state_q == BUSY && cnt_q == '0);
  assign op_we      = in_idle ? bus.req_we        : we_q;
  assign op_uns     = in_idle ? bus.req_unsigned  : uns_q;
  assign op_addr    = in_idle ? bus.req_addr      : addr_q;
  assign op_size    = in_idle ? bus.req_size      : size_q;
  assign op_wdata   = in_idle ? bus.req_wdata     : wdata_q;
  assign idx        = op_addr[ADDR_W-1:2];

`ifdef DMEM_MISALIGN_CHK_EN
  assign lo      = op_addr[1:0];
  assign err_mis = (op_size == SZ_H && op_addr[0]) || (op_size == SZ_W && op_addr[1:0] != 2'b00);
`else
  assign lo      = (op_size == SZ_H) ? {op_addr[1], 1'b0} :
                   (op_size == SZ_W) ? 2'b00 : op_addr[1:0];
  assign err_mis = 1'b0;
`endif

  assign err   = (idx >= DEPTH_L) || (op_size == SZ_RSVD) || err_mis;
  assign rword = DM[idx[AW-1:0]];
  assign wr_en = enter_resp && op_we && !err;

  dmem_lane_align u_align (
    .size_i  (op_size),
    .lo_i    (lo),
    .uns_i   (op_uns),
    .wdata_i (op_wdata),
    .rword_i (rword),
    .be_o    (be),
    .wrep_o  (wrep),
    .rdata_o (ld_data)
  );

  // Memory array is not reset; a store commits only on the RESP-entry edge.
  always @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) DM[idx[AW-1:0]][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      size_q      <= SZ_B;
      wdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            we_q        <= bus.req_we;
            uns_q       <= bus.req_unsigned;
            addr_q      <= bus.req_addr;
            size_q      <= bus.req_size;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            if (NO_WAIT) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= (op_we || err) ? 32'h0 : ld_data;
              rsp_err_q   <= err;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= (op_we || err) ? 32'h0 : ld_data;
            rsp_err_q   <= err;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued when a
// request is issued and compared when the response appears.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int WAIT  = 1;
  localparam int DEPTH = 256;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_W(AW)) bus ();

  dmem_responder #(
    .ADDR_W      (AW),
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", tag, got, exp);
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic e);
    exp_t x;
    x.rdata = rd;
    x.err   = e;
    sb_q.push_back(x);
  endtask

  // Present a request and return at the negedge after the accept edge.
  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input size_e sz, input logic uns, input logic [31:0] wd);
    int k = 0;
    @(negedge clk);
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      chk({tag, "_acc_tmo"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Wait for rsp_valid, check latency, compare against the scoreboard head.
  task automatic collect(input string tag);
    int   lat = 1;
    exp_t e;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(WAIT + 1));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
    chk({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input size_e sz, input logic uns, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    push_exp(exp_rd, exp_err);
    issue(tag, we, addr, sz, uns, wd);
    collect(tag);
    @(negedge clk);
    chk({tag, "_vld_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    logic        stray;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b1;
    dut.DM[0] = 32'h8765_4321;
    dut.DM[1] = 32'hCAFE_F00D;
    dut.DM[2] = 32'h0BAD_BEEF;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err",   {31'b0, bus.rsp_err},   32'd0);
    rst_n = 1'b1;

    // Loads with extension.
    xact("lb3",  1'b0, 32'h3, SZ_B, 1'b0, 32'h0, 32'hFFFF_FF87, 1'b0);
    xact("lbu3", 1'b0, 32'h3, SZ_B, 1'b1, 32'h0, 32'h0000_0087, 1'b0);
    xact("lh2",  1'b0, 32'h2, SZ_H, 1'b0, 32'h0, 32'hFFFF_8765, 1'b0);
    xact("lhu0", 1'b0, 32'h0, SZ_H, 1'b1, 32'h0, 32'h0000_4321, 1'b0);
    xact("lw0",  1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'h8765_4321, 1'b0);
    xact("lb1",  1'b0, 32'h1, SZ_B, 1'b0, 32'h0, 32'h0000_0043, 1'b0);

    // Sub-word stores and read-back.
    xact("sb1",   1'b1, 32'h1, SZ_B, 1'b0, 32'h0000_00AB, 32'h0, 1'b0);
    xact("lw0b",  1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'h8765_AB21, 1'b0);
    xact("lb1s",  1'b0, 32'h1, SZ_B, 1'b0, 32'h0, 32'hFFFF_FFAB, 1'b0);
    xact("sh2",   1'b1, 32'h2, SZ_H, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0);
    xact("lw0h",  1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'hBEEF_AB21, 1'b0);

    // Misalignment handling.
`ifdef DMEM_MISALIGN_CHK_EN
    xact("lh1_mis", 1'b0, 32'h1, SZ_H, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("lw2_mis", 1'b0, 32'h2, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("sw1_mis", 1'b1, 32'h1, SZ_W, 1'b0, 32'hDEAD_DEAD, 32'h0, 1'b1);
`else
    xact("lh1_aln", 1'b0, 32'h1, SZ_H, 1'b0, 32'h0, 32'hFFFF_AB21, 1'b0);
    xact("lw2_aln", 1'b0, 32'h2, SZ_W, 1'b0, 32'h0, 32'hBEEF_AB21, 1'b0);
`endif
    xact("lw0_chk", 1'b0, 32'h0, SZ_W, 1'b0, 32'h0, 32'hBEEF_AB21, 1'b0);

    // Out-of-range and reserved size.
    xact("lw_oob", 1'b0, 32'(4 * DEPTH), SZ_W, 1'b0, 32'h0, 32'h0, 1'b1);
    xact("sw_oob", 1'b1, 32'(4 * DEPTH), SZ_W, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
    xact("rsvd",   1'b0, 32'h0, SZ_RSVD, 1'b0, 32'h0, 32'h0, 1'b1);

    // Backpressure: response holds, new request ignored while stalled.
    bus.rsp_ready = 1'b0;
    push_exp(32'hBEEF_AB21, 1'b0);
    issue("bp", 1'b0, 32'h0, SZ_W, 1'b0, 32'h0);
    collect("bp");
    held = bus.rsp_rdata;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h8;
    bus.req_size  = SZ_W;
    bus.req_wdata = 32'h55AA_55AA;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_rdata", bus.rsp_rdata, held);
      chk("bp_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("bp_drop", {31'b0, bus.rsp_valid}, 32'd0);
    xact("lw8", 1'b0, 32'h8, SZ_W, 1'b0, 32'h0, 32'h0BAD_BEEF, 1'b0);

    // Reset while BUSY abandons the store.
    issue("rstb", 1'b1, 32'h4, SZ_W, 1'b0, 32'h1234_5678);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstb_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rstb_ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid) stray = 1'b1;
    end
    chk("rstb_stray", {31'b0, stray}, 32'd0);
    xact("lw4", 1'b0, 32'h4, SZ_W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
